// File: rtl/sec_pkg.sv
// Shared definitions for the bit-serial equality comparator:
// FSM state encoding and default operand geometry.
package sec_pkg;

    localparam int unsigned SEC_WIDTH = 6;
    localparam int unsigned SEC_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of bit_count must hold the value WIDTH itself
    function automatic bit cnt_width_ok(input int unsigned width, input int unsigned cnt_w);
        return (64'd1 << cnt_w) > 64'(width);
    endfunction

endpackage

// File: rtl/serial_equal_comparator_if.sv
// Serial operand stream plus result/status signals of the equality comparator.
interface serial_equal_comparator_if #(
    parameter int unsigned CNT_W = 6
);
    logic             start;
    logic             in_valid;
    logic             x_bit;
    logic             y_bit;
    logic             busy;
    logic             done;
    logic             igual;
    logic [CNT_W-1:0] bit_count;

    modport master (
        output start, in_valid, x_bit, y_bit,
        input  busy, done, igual, bit_count
    );

    modport slave (
        input  start, in_valid, x_bit, y_bit,
        output busy, done, igual, bit_count
    );
endinterface

// File: rtl/serial_eq_cell.sv
// One-bit XNOR feeding an AND accumulator: eq stays 1 only while every
// enabled bit pair has matched since the last clear.
module serial_eq_cell (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic eq
);

    always_ff @(posedge clk) begin
        if (reset || clr)
            eq <= 1'b1;
        else if (en)
            eq <= eq & (a ~^ b);
    end

endmodule

// File: rtl/serial_equal_comparator.sv
// Bit-serial equality comparator: accepts WIDTH bit pairs LSB first and
// reports igual with a one-cycle done pulse; all outputs registered.
module serial_equal_comparator
    import sec_pkg::*;
#(
    parameter int unsigned WIDTH = SEC_WIDTH,
    parameter int unsigned CNT_W = SEC_CNT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    serial_equal_comparator_if.slave      bus
);

    state_t           state, state_next;
    logic             busy_q, busy_next;
    logic             done_q, done_next;
    logic             igual_q, igual_next;
    logic [CNT_W-1:0] cnt_q, cnt_next;
    logic             cell_clr, cell_en, eq_acc;
    logic             pair_eq;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

    initial begin
        assert (WIDTH >= 2 && WIDTH <= 32 && cnt_width_ok(WIDTH, CNT_W))
            else $fatal(1, "serial_equal_comparator: illegal WIDTH/CNT_W");
    end

    assign pair_eq = bus.x_bit ~^ bus.y_bit;

    serial_eq_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .clr   (cell_clr),
        .en    (cell_en),
        .a     (bus.x_bit),
        .b     (bus.y_bit),
        .eq    (eq_acc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            igual_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_next;
            busy_q  <= busy_next;
            done_q  <= done_next;
            igual_q <= igual_next;
            cnt_q   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_next  = busy_q;
        done_next  = 1'b0;
        igual_next = igual_q;
        cnt_next   = cnt_q;
        cell_clr   = 1'b0;
        cell_en    = 1'b0;

        case (state)
            ST_IDLE: begin
                busy_next = 1'b0;
                if (bus.start) begin
                    state_next = ST_RUN;
                    busy_next  = 1'b1;
                    cnt_next   = '0;
                    cell_clr   = 1'b1;
                end
            end
            ST_RUN: begin
                busy_next = 1'b1;
                if (bus.in_valid) begin
                    cell_en  = 1'b1;
                    cnt_next = cnt_q + 1'b1;
                    // Final pair folds straight into igual, bypassing the accumulator latency
                    if (cnt_q == LAST_IDX) begin
                        state_next = ST_DONE;
                        igual_next = eq_acc & pair_eq;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        cnt_next   = FULL_CNT;
                    end
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_next = ST_RUN;
                    busy_next  = 1'b1;
                    cnt_next   = '0;
                    cell_clr   = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
                cnt_next   = '0;
                cell_clr   = 1'b1;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.igual     = igual_q;
    assign bus.bit_count = cnt_q;

endmodule

// File: tb/tb_serial_equal_comparator.sv
// Scoreboard bench for serial_equal_comparator (WIDTH=6): expected igual
// values are queued at stimulus time and popped on each done pulse.
module tb_serial_equal_comparator;

    localparam int unsigned W  = 6;
    localparam int unsigned CW = 6;

    logic clk;
    logic reset;

    serial_equal_comparator_if #(.CNT_W(CW)) bus ();

    serial_equal_comparator #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic        sb_q[$];
    int unsigned cyc      = 0;
    int unsigned last_done_cyc = 0;
    int unsigned prev_done_cyc = 0;
    int unsigned done_seen     = 0;
    logic        done_prev     = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Result monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (done_prev)
                check("done_one_cycle", 32'(bus.done), 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                check("igual", 32'(bus.igual), 32'(sb_q.pop_front()));
                check("count_at_done", 32'(bus.bit_count), 32'(W));
                check("busy_at_done", 32'(bus.busy), 32'd0);
            end
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            done_seen++;
        end
        done_prev = bus.done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmp();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Feed W pairs LSB first; gap_mask[i] inserts one idle cycle after pair i
    task automatic feed(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] gap_mask);
        sb_q.push_back(x == y);
        for (int i = 0; i < int'(W); i++) begin
            bus.in_valid = 1'b1;
            bus.x_bit    = x[i];
            bus.y_bit    = y[i];
            tick();
            bus.in_valid = 1'b0;
            if (i < int'(W) - 1) begin
                check("count_progress", 32'(bus.bit_count), 32'(i + 1));
                check("no_early_done", 32'(bus.done), 32'd0);
            end
            if (gap_mask[i] && i < int'(W) - 1) begin
                tick();
                check("stall_hold", 32'(bus.bit_count), 32'(i + 1));
            end
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.x_bit    = 1'b0;
        bus.y_bit    = 1'b0;

        // 1: reset dominates start/in_valid
        reset        = 1'b1;
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_igual", 32'(bus.igual), 32'd0);
        check("rst_count", 32'(bus.bit_count), 32'd0);
        tick();
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        tick();

        // 2: equal operands, no gaps
        start_cmp();
        check("busy_in_run", 32'(bus.busy), 32'd1);
        feed(6'b101010, 6'b101010, 6'b000000);
        check("t2_done", 32'(bus.done), 32'd1);
        tick();
        check("t2_done_drop", 32'(bus.done), 32'd0);
        check("t2_igual_hold", 32'(bus.igual), 32'd1);

        // 3: LSB mismatch, stalls after 2nd and 4th pair
        start_cmp();
        check("t3_igual_unchanged", 32'(bus.igual), 32'd1);
        feed(6'b101010, 6'b101011, 6'b001010);
        check("t3_done", 32'(bus.done), 32'd1);
        tick();

        // 4: back-to-back, start held during the DONE cycle
        start_cmp();
        feed(6'b111111, 6'b111111, 6'b000000);
        check("t4_first_done", 32'(bus.done), 32'd1);
        start_cmp();
        check("t4_busy_again", 32'(bus.busy), 32'd1);
        check("t4_count_reinit", 32'(bus.bit_count), 32'd0);
        feed(6'b110011, 6'b101011, 6'b000000);
        check("t4_second_done", 32'(bus.done), 32'd1);
        tick();
        check("t4_spacing", last_done_cyc - prev_done_cyc, 32'(W + 1));

        // igual=1 beforehand so the reset clearing it is observable
        start_cmp();
        feed(6'b011001, 6'b011001, 6'b000000);
        tick();
        check("pre5_igual", 32'(bus.igual), 32'd1);

        // 5: reset part-way through a comparison
        start_cmp();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.x_bit    = (i == 0);
            bus.y_bit    = (i == 0);
            tick();
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_igual_cleared", 32'(bus.igual), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_count", 32'(bus.bit_count), 32'd0);
        tick();
        check("t5_no_done", 32'(bus.done), 32'd0);
        start_cmp();
        for (int i = 0; i < 10; i++) tick();
        check("t5_stalled_busy", 32'(bus.busy), 32'd1);
        check("t5_stalled_done", 32'(bus.done), 32'd0);
        check("t5_stalled_count", 32'(bus.bit_count), 32'd0);
        feed(6'b000001, 6'b000001, 6'b000000);
        tick();

        // 6: in_valid in IDLE and a start pulse during RUN are both ignored
        bus.in_valid = 1'b1;
        bus.x_bit    = 1'b1;
        bus.y_bit    = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus.in_valid = 1'b0;
        check("t6_idle_count", 32'(bus.bit_count), 32'(W));
        check("t6_idle_busy", 32'(bus.busy), 32'd0);
        start_cmp();
        sb_q.push_back(1'b0);
        for (int i = 0; i < int'(W); i++) begin
            bus.in_valid = (i != 3);
            bus.start    = (i == 2 || i == 3);
            bus.x_bit    = 1'b1;
            bus.y_bit    = (i != 4);
            tick();
            if (i == 3) check("t6_start_ignored", 32'(bus.bit_count), 32'd3);
        end
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.y_bit    = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check("t6_done", 32'(bus.done), 32'd1);
        check("t6_count", 32'(bus.bit_count), 32'(W));
        tick();
        // start was low in DONE so the comparator returns to IDLE
        check("t6_back_idle", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 3; i++) tick();
        check("sb_drained", sb_q.size(), 32'd0);
        check("done_total", done_seen, 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
